// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: two requesters share one external combinational ALU.
// Round-robin arbitration, one-entry result buffer per requester,
// result visible the cycle after the request is accepted.
// Optional build macro ALU_SHARE_ILLEGAL_OP_EN flags results produced from
// illegal ALU control codes on resp0_err/resp1_err; without it they are tied 0.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [3:0]       req0_ctrl,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_data,
    output logic             resp0_err,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [3:0]       req1_ctrl,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_data,
    output logic             resp1_err,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_ctrl,
    input  logic [WIDTH-1:0] alu_out,

    output logic [CNT_W-1:0] op_count
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } buf_state_t;

    buf_state_t       state0;
    buf_state_t       state1;
    logic             rr_ptr;
    logic             elig0;
    logic             elig1;
    logic             grant0;
    logic             grant1;
    logic [WIDTH-1:0] last_a;
    logic [WIDTH-1:0] last_b;
    logic [3:0]       last_ctrl;

    assign resp0_valid = (state0 == FULL);
    assign resp1_valid = (state1 == FULL);

    // A port competes when it has work and its buffer will have room at the edge;
    // a conflict goes to the port named by rr_ptr.
    always_comb begin
        elig0  = req0_valid && ((state0 == EMPTY) || resp0_ready);
        elig1  = req1_valid && ((state1 == EMPTY) || resp1_ready);
        grant0 = elig0 && (!elig1 || (rr_ptr == 1'b0));
        grant1 = elig1 && (!elig0 || (rr_ptr == 1'b1));
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Steer the granted port onto the shared ALU; hold the last operation when idle.
    always_comb begin
        alu_a    = last_a;
        alu_b    = last_b;
        alu_ctrl = last_ctrl;
        if (grant0) begin
            alu_a    = req0_a;
            alu_b    = req0_b;
            alu_ctrl = req0_ctrl;
        end else if (grant1) begin
            alu_a    = req1_a;
            alu_b    = req1_b;
            alu_ctrl = req1_ctrl;
        end
    end

    // Remember the last granted operation, flip priority and count accepted ops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_a    <= '0;
            last_b    <= '0;
            last_ctrl <= '0;
            rr_ptr    <= 1'b0;
            op_count  <= '0;
        end else if (grant0 || grant1) begin
            last_a    <= alu_a;
            last_b    <= alu_b;
            last_ctrl <= alu_ctrl;
            rr_ptr    <= grant0;
            op_count  <= op_count + CNT_W'(1);
        end
    end

    // Requester 0 result buffer: capture on grant, release on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state0     <= EMPTY;
            resp0_data <= '0;
        end else begin
            case (state0)
                EMPTY: begin
                    if (grant0) begin
                        state0     <= FULL;
                        resp0_data <= alu_out;
                    end
                end
                FULL: begin
                    if (grant0) begin
                        resp0_data <= alu_out;
                    end else if (resp0_ready) begin
                        state0 <= EMPTY;
                    end
                end
                default: state0 <= EMPTY;
            endcase
        end
    end

    // Requester 1 result buffer: capture on grant, release on consume.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state1     <= EMPTY;
            resp1_data <= '0;
        end else begin
            case (state1)
                EMPTY: begin
                    if (grant1) begin
                        state1     <= FULL;
                        resp1_data <= alu_out;
                    end
                end
                FULL: begin
                    if (grant1) begin
                        resp1_data <= alu_out;
                    end else if (resp1_ready) begin
                        state1 <= EMPTY;
                    end
                end
                default: state1 <= EMPTY;
            endcase
        end
    end

`ifdef ALU_SHARE_ILLEGAL_OP_EN
    logic ctrl_illegal;

    assign ctrl_illegal = !(alu_ctrl inside {4'b0000, 4'b0001, 4'b0010,
                                             4'b0110, 4'b0111, 4'b1100});

    // Error flags travel with the captured data of each buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp0_err <= 1'b0;
            resp1_err <= 1'b0;
        end else begin
            if (grant0) resp0_err <= ctrl_illegal;
            if (grant1) resp1_err <= ctrl_illegal;
        end
    end
`else
    assign resp0_err = 1'b0;
    assign resp1_err = 1'b0;
`endif

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one combinational ALU (4-bit control encoding) between two requesters, e.g. the execute stage (port 0) and a branch/compare helper (port 1).
- Round-robin arbitration with valid/ready handshakes.
- Drives the shared ALU operand/control inputs and captures the result into a one-entry response buffer per requester.
- Result latency is 1 cycle after the accepted request.

Parameters:
- WIDTH, 32, operand/result width.
- CNT_W, 16, width of the issued-operation counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_a, req0_b  in  WIDTH  requester 0 operands.
- req0_ctrl  in  4  requester 0 ALU control code.
- resp0_valid  out  1  requester 0 result buffer full.
- resp0_ready  in  1  requester 0 consumes result.
- resp0_data  out  WIDTH  requester 0 result.
- resp0_err  out  1  requester 0 result came from an illegal control code.
- req1_*, resp1_*  as port 0, for requester 1.
- alu_a, alu_b  out  WIDTH  shared ALU operands.
- alu_ctrl  out  4  shared ALU control.
- alu_out  in  WIDTH  shared ALU result (combinational from alu_a/alu_b/alu_ctrl).
- op_count  out  CNT_W  total accepted operations, wraps.

Behaviour:
- Reset (rst_n low, async): resp0/1_valid=0, resp0/1_data=0, resp0/1_err=0, op_count=0, rr_ptr=0 (port 0 has priority first).
- Eligibility: port i is eligible when reqi_valid=1 and its buffer is empty or drains this cycle (resp_valid & resp_ready).
- Grant: at most one port per cycle.
  - Only one eligible port: that port is granted.
  - Both eligible: the port selected by rr_ptr is granted.
- reqi_ready = grant[i], combinational. Ready may depend on valid; requesters must not make valid depend on ready.
- Per-requester buffer FSM, states EMPTY/FULL:
  - EMPTY -> FULL on grant.
  - FULL -> EMPTY on resp_ready with no new grant.
  - FULL -> FULL on drain plus grant in the same cycle; the buffer is overwritten with the new result.
- ALU drive while port g is granted: alu_a, alu_b, alu_ctrl = port g's req_a, req_b, req_ctrl.
- ALU drive when idle: alu_a, alu_b, alu_ctrl hold the last granted values. Nothing is captured.
- Capture on grant, at the clock edge: resp_g_data <= alu_out, resp_g_valid <= 1. Data appears the cycle after acceptance.
- resp_data stays stable while resp_valid=1 and resp_ready=0.
- rr_ptr update:
  - After a grant to port g, rr_ptr <= ~g, so the other port wins the next conflict.
  - No grant: rr_ptr unchanged.
- op_count increments by 1 per grant and wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: pending results are discarded and no response is issued. Requesters re-issue.
- Legal control codes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR. All other codes are illegal.
- The arbiter never alters the ALU result: illegal codes pass through and the ALU returns 0.

Optional Feature:
- Macro: ALU_SHARE_ILLEGAL_OP_EN.
- Defined:
  - resp_i_err <= 1 captured with a result whose alu_ctrl was illegal; 0 for legal codes.
  - resp_i_err is held with the data.
- Undefined: resp0_err and resp1_err tied to 0, no decode logic.

Test Plan:
- Port 0 only, a=5, b=3, ctrl=0010 -> req0_ready=1 same cycle; next cycle resp0_valid=1, resp0_data=8; op_count=1.
- Both valid every cycle, resp_ready=1, port 0 ctrl=0110 (7-2), port 1 ctrl=0111 (2<7) -> grants alternate 0,1,0,1 starting at port 0; results 5 and 1 respectively; op_count=4 after 4 cycles.
- Port 1 result unconsumed (resp1_ready=0), port 1 valid -> req1_ready=0 while full and port 0 still served. Raising resp1_ready with req1_valid high gives same-cycle drain plus grant, and the new data appears next cycle.
- Assert rst_n low mid-stream with both buffers full -> resp0/1_valid=0 and op_count=0 immediately (asynchronous); the first grant after release goes to port 0.
- op_count preset by issuing 65535 ops, then one more -> op_count=0.
- ctrl=1111, a=1, b=1 -> resp_data=0; resp_err=1 with ALU_SHARE_ILLEGAL_OP_EN defined, 0 without.
